// File: rtl/nios_system_switch_poller_pkg.sv
// Shared definitions for the switch poller: poll FSM encoding and the
// register address of the switch PIO data port.
package nios_system_switch_poller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2
  } poll_state_t;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/nios_system_poll_timer.sv
// Poll interval down-counter: ticks once every POLL_DIV enabled cycles and
// is held at its reload value whenever enable is low.
module nios_system_poll_timer #(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= RELOAD;
    end else if (!enable || (count == '0)) begin
      count <= RELOAD;
    end else begin
      count <= count - CNT_W'(1);
    end
  end

  assign tick = enable && (count == '0);

endmodule

// File: rtl/nios_system_switch_poller.sv
// Avalon-MM read master that polls the switch PIO, debounces the samples and
// publishes a stable switch vector with change pulse, change mask and sticky irq.
module nios_system_switch_poller
  import nios_system_switch_poller_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_CNT   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        m_address,
  output logic              m_read,
  input  logic [31:0]       m_readdata,
  output logic [DATA_W-1:0] switches_out,
  output logic [DATA_W-1:0] changed_bits,
  output logic              change_pulse,
  output logic              irq,
  input  logic              irq_ack
);

  localparam int SC_W  = $clog2(STABLE_CNT + 1);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  poll_state_t       state, state_next;
  logic              poll_tick;
  logic              sample_strobe;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] candidate, cand_next;
  logic [SC_W-1:0]   stable_cnt, cnt_next;
  logic              accept;

  nios_system_poll_timer #(
    .POLL_DIV(POLL_DIV)
  ) u_poll_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (poll_tick)
  );

  generate
    if (DATA_W < 32) begin : g_upper_bits
      logic unused_upper;
      assign unused_upper = ^m_readdata[31:DATA_W];
    end
  endgenerate

  assign m_address     = PIO_DATA_ADDR;
  assign sample        = m_readdata[DATA_W-1:0];
  assign sample_strobe = (state == WAIT) && (lat_cnt == LAT_W'(READ_LATENCY));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A poll tick arriving outside IDLE is dropped; POLL_DIV >= READ_LATENCY+2 keeps that from happening.
  always_comb begin
    state_next = state;
    m_read     = 1'b0;
    case (state)
      IDLE: if (poll_tick) state_next = READ;
      READ: begin
        m_read     = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (sample_strobe) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt <= '0;
    end else if (state == READ) begin
      lat_cnt <= LAT_W'(1);
    end else if ((state == WAIT) && !sample_strobe) begin
      lat_cnt <= lat_cnt + LAT_W'(1);
    end
  end

  // Acceptance looks at the post-update count so STABLE_CNT=1 accepts on the loading sample.
  always_comb begin
    cand_next = candidate;
    cnt_next  = stable_cnt;
    accept    = 1'b0;
    if (sample_strobe) begin
      if (sample != candidate) begin
        cand_next = sample;
        cnt_next  = SC_W'(1);
      end else if (stable_cnt != SC_W'(STABLE_CNT)) begin
        cnt_next = stable_cnt + SC_W'(1);
      end
      accept = (cnt_next == SC_W'(STABLE_CNT)) && (cand_next != switches_out);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate    <= '0;
      stable_cnt   <= '0;
      switches_out <= '0;
      changed_bits <= '0;
      change_pulse <= 1'b0;
      irq          <= 1'b0;
    end else begin
      candidate    <= cand_next;
      stable_cnt   <= cnt_next;
      change_pulse <= accept;
      if (accept) begin
        switches_out <= cand_next;
        changed_bits <= cand_next ^ switches_out;
      end
      if (accept) begin
        irq <= 1'b1;
      end else if (irq_ack) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios_system_switch_poller.sv
// Bench for the switch poller: a poll-count/sample-window model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_nios_system_switch_poller;

  localparam int P  = 8;
  localparam int SC = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable = 1'b0;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] m_readdata = '0;
  logic [7:0]  switches_out;
  logic [7:0]  changed_bits;
  logic        change_pulse;
  logic        irq;
  logic        irq_ack = 1'b0;

  logic [7:0]  sw_val = 8'h00;
  logic [23:0] upper  = 24'h000000;

  int checks = 0;
  int errors = 0;
  int read_cnt = 0;
  int pulse_cnt = 0;

  nios_system_switch_poller #(
    .DATA_W(8), .POLL_DIV(P), .STABLE_CNT(SC), .READ_LATENCY(1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .m_address   (m_address),
    .m_read      (m_read),
    .m_readdata  (m_readdata),
    .switches_out(switches_out),
    .changed_bits(changed_bits),
    .change_pulse(change_pulse),
    .irq         (irq),
    .irq_ack     (irq_ack)
  );

  always #5 clk = ~clk;

  // Slave registers its data every cycle, giving a read latency of one.
  always @(posedge clk) m_readdata <= {upper, sw_val};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: reads fall on every P-th consecutive enabled edge; a value is
  // accepted when the last SC samples agree and differ from the published one.
  int         en_run;
  bit         rd_pend;
  logic       exp_read;
  logic [7:0] exp_sw, exp_changed;
  logic       exp_pulse, exp_irq, model_accept;
  logic [7:0] hist[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_run = 0; rd_pend = 0; exp_read = 0; exp_sw = 0; exp_changed = 0;
      exp_pulse = 0; exp_irq = 0; model_accept = 0;
      hist.delete();
    end else begin
      model_accept = 0;
      if (rd_pend) begin
        hist.push_back(m_readdata[7:0]);
        if (hist.size() > SC) void'(hist.pop_front());
        model_accept = (hist.size() == SC) && (hist[0] != exp_sw);
        for (int i = 1; i < hist.size(); i++)
          if (hist[i] != hist[0]) model_accept = 0;
      end
      exp_pulse = model_accept;
      if (model_accept) begin
        exp_changed = hist[0] ^ exp_sw;
        exp_sw      = hist[0];
        exp_irq     = 1;
      end else if (irq_ack) begin
        exp_irq = 0;
      end
      rd_pend  = exp_read;
      en_run   = enable ? en_run + 1 : 0;
      exp_read = (en_run > 0) && (en_run % P == 0);
    end
  end

  always @(negedge clk) begin
    checkOutput("m_read", m_read, exp_read);
    checkOutput("m_address", m_address, 2'd0);
    checkOutput("switches_out", switches_out, exp_sw);
    checkOutput("changed_bits", changed_bits, exp_changed);
    checkOutput("change_pulse", change_pulse, exp_pulse);
    checkOutput("irq", irq, exp_irq);
    if (m_read) read_cnt++;
    if (change_pulse) pulse_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] sw, input logic ack);
    enable  = en;
    sw_val  = sw;
    irq_ack = ack;
  endtask

  task automatic waitRead();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_read && n < 40);
    if (!m_read) checkOutput("m_read_timeout", 32'd0, 32'd1);
  endtask

  task automatic doPoll(input logic [7:0] v);
    sw_val = v;
    waitRead();
    tick();
  endtask

  task automatic doReset();
    tick();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  int rc, pc, n;

  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    $display("[TB] idle with enable low");
    repeat (50) tick();
    checkOutput("idle_reads", read_cnt, 0);
    checkOutput("idle_switches", switches_out, 8'h00);
    checkOutput("idle_irq", irq, 1'b0);

    $display("[TB] basic accept");
    applyStimulus(1'b1, 8'hA5, 1'b0);
    doPoll(8'hA5);
    doPoll(8'hA5);
    tick();
    checkOutput("basic_not_yet", switches_out, 8'h00);
    doPoll(8'hA5);
    tick();
    checkOutput("basic_pulse", change_pulse, 1'b1);
    checkOutput("basic_switches", switches_out, 8'hA5);
    checkOutput("basic_changed", changed_bits, 8'hA5);
    checkOutput("basic_irq", irq, 1'b1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("basic_irq_ack", irq, 1'b0);
    checkOutput("basic_pulse_once", change_pulse, 1'b0);

    $display("[TB] bounce");
    doReset();
    pc = pulse_cnt;
    doPoll(8'hA5);
    doPoll(8'h5A);
    doPoll(8'hA5);
    doPoll(8'hA5);
    tick();
    checkOutput("bounce_hold", switches_out, 8'h00);
    checkOutput("bounce_no_pulse", pulse_cnt - pc, 0);
    doPoll(8'hA5);
    tick();
    checkOutput("bounce_switches", switches_out, 8'hA5);
    checkOutput("bounce_one_pulse", pulse_cnt - pc, 1);
    doPoll(8'hA5);
    doPoll(8'hA5);
    tick();
    checkOutput("bounce_still_one", pulse_cnt - pc, 1);

    $display("[TB] toggle with upper bits set");
    upper = 24'hFFFFFF;
    doPoll(8'h0F);
    doPoll(8'h0F);
    doPoll(8'h0F);
    tick();
    checkOutput("toggle_0f", switches_out, 8'h0F);
    checkOutput("toggle_changed_aa", changed_bits, 8'hAA);
    doPoll(8'h0E);
    doPoll(8'h0E);
    doPoll(8'h0E);
    tick();
    checkOutput("toggle_0e", switches_out, 8'h0E);
    checkOutput("toggle_changed_01", changed_bits, 8'h01);

    $display("[TB] simultaneous accept and ack");
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
    checkOutput("sim_irq_cleared", irq, 1'b0);
    doPoll(8'h33);
    doPoll(8'h33);
    sw_val = 8'h33;
    waitRead();
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("sim_pulse", change_pulse, 1'b1);
    checkOutput("sim_irq_kept", irq, 1'b1);
    pc = pulse_cnt;
    doPoll(8'h33);
    doPoll(8'h33);
    doPoll(8'h33);
    tick();
    checkOutput("same_value_no_pulse", pulse_cnt - pc, 0);

    $display("[TB] enable drop mid-transaction");
    doPoll(8'h44);
    doPoll(8'h44);
    sw_val = 8'h44;
    waitRead();
    enable = 1'b0;
    tick();
    tick();
    checkOutput("drop_switches", switches_out, 8'h44);
    rc = read_cnt;
    repeat (30) tick();
    checkOutput("drop_no_reads", read_cnt - rc, 0);

    $display("[TB] reset during wait");
    applyStimulus(1'b1, 8'h55, 1'b0);
    waitRead();
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("rst_switches", switches_out, 8'h00);
    checkOutput("rst_changed", changed_bits, 8'h00);
    checkOutput("rst_irq", irq, 1'b0);
    checkOutput("rst_m_read", m_read, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_read && n < 40);
    checkOutput("rst_first_read", n, P);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/nios_system_switch_poller.md
Name: nios_system_switch_poller

Overview:
Avalon-MM read master that periodically polls the 8-bit switch PIO slave (fixed read latency, no waitrequest) at address 0. It debounces the sampled value over consecutive polls and publishes a stable switch vector. It also emits a one-cycle change event with a changed-bit mask and a sticky interrupt. Sits between the switch PIO slave and game/control logic that must not see raw switch bounce.

Parameters:
DATA_W, 8, width of switch field taken from m_readdata[DATA_W-1:0]
POLL_DIV, 50000, clock cycles between successive m_read assertions; must be >= READ_LATENCY+2
STABLE_CNT, 4, consecutive identical samples required to accept a value; >= 1
READ_LATENCY, 1, cycles from m_read to valid m_readdata; >= 1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  polling enable
m_address  out  2  Avalon address, constant 0
m_read  out  1  Avalon read strobe, one cycle per poll
m_readdata  in  32  slave read data; bits above DATA_W ignored
switches_out  out  DATA_W  debounced switch vector
changed_bits  out  DATA_W  XOR of new and previous switches_out, held until next change
change_pulse  out  1  one-cycle strobe when switches_out updates
irq  out  1  sticky change interrupt
irq_ack  in  1  clears irq

Behaviour:
- Reset (async, reset_n=0): m_read=0, m_address=0, switches_out=0, changed_bits=0, change_pulse=0, irq=0, candidate=0, stable count=0, timer=POLL_DIV-1, FSM=IDLE.
- Poll timer: free-running down-counter, active only while enable=1. On reaching 0 it requests a poll and reloads POLL_DIV-1. While enable=0 it is held at POLL_DIV-1. First m_read occurs POLL_DIV cycles after enable rises; period thereafter is exactly POLL_DIV cycles.
- FSM states:
  - IDLE -> READ on poll request.
  - READ: m_read=1 for exactly one cycle, address 0. Go to WAIT.
  - WAIT: latency counter runs. On cycle READ_LATENCY after READ, sample m_readdata[DATA_W-1:0] at that clock edge. Return to IDLE.
- enable falling mid-transaction: the in-flight read completes and its sample is processed. No new read is issued.
- Debounce on each sample s:
  - s != candidate: candidate <= s, count <= 1.
  - s == candidate: count <= count+1, saturating at STABLE_CNT.
  - Accept when the post-update count equals STABLE_CNT and candidate != switches_out. This includes the STABLE_CNT=1 case, where acceptance happens on the same sample that loads the candidate.
- Accept effects, all registered and visible the cycle after the sample edge:
  - switches_out <= candidate.
  - changed_bits <= candidate ^ old switches_out.
  - change_pulse=1 for one cycle.
  - irq <= 1.
- A stable value equal to switches_out, including the initial 0 after reset, produces no event.
- irq: set on accept, cleared by irq_ack=1. Simultaneous accept and irq_ack leaves irq=1.
- Counter widths: timer ceil(log2(POLL_DIV)); count ceil(log2(STABLE_CNT+1)); latency ceil(log2(READ_LATENCY+1)).

Decomposition:
- Shared package: FSM state encoding (IDLE, READ, WAIT), and the constant PIO data register address = 0.
- One natural sub-module: nios_system_poll_timer (parameterised down-counter with enable/reload, outputs tick).
- FSM and debounce stay in the top module.

Test Plan (bench: POLL_DIV=8, STABLE_CNT=3, READ_LATENCY=1, slave model registers readdata each cycle):
- Reset/idle: enable=0 for 50 cycles -> m_read never asserted; all outputs 0, irq 0.
- Basic accept: enable=1, switches=8'hA5 constant -> m_read every 8 cycles. After 3rd sample, switches_out=8'hA5, changed_bits=8'hA5, change_pulse one cycle, irq=1. irq_ack clears irq next cycle.
- Bounce: samples A5,5A,A5,A5,A5 -> no accept until the 3rd consecutive A5. Exactly one change_pulse.
- Toggle: stable 8'h0F then 8'h0E -> changed_bits=8'h01. Upper m_readdata bits driven 0xFFFFFF00 ignored.
- Simultaneous: irq_ack asserted in the accept cycle -> irq remains 1. Stable value equal to current switches_out -> no pulse.
- Mid-operation: drop enable the cycle after m_read -> sample still captured, no further m_read. Assert reset_n=0 mid-WAIT -> outputs 0 immediately; first m_read POLL_DIV cycles after reset release with enable=1.
